// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   ALU control stage between the main control/register-file read and the ALU.
//   Decodes the control opcode (and the funct field for R-type) into an ALU
//   command. The command and both operands are registered and offered to the
//   ALU over a valid/ready handshake. A MUL keeps the ALU busy for MUL_LAT
//   cycles from its acceptance, and upstream is stalled for that time.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | output register empty, ready for a new instruction
//   FULL  | command/operands presented to the ALU (out_valid = 1)
//   MULW  | accepted MUL still occupies the ALU; outputs held, busy = 1
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready upstream handshake (in_ready is combinational)
//   Op_from_control   control opcode (15 = R-type, decode fonction)
//   fonction          MIPS funct field
//   reg1, reg2        operands, sampled only at capture
//   out_valid/out_ready  ALU handshake
//   ctrl_command      registered ALU command
//   outreg1, outreg2  registered operands
//   illegal           registered: the captured opcode/funct was undefined
//   busy              a multiply is in progress
module alu_issue_ctrl #(
    parameter int DATA_W  = 32,
    parameter int CMD_W   = 4,
    parameter int MUL_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        Op_from_control,
    input  logic [5:0]        fonction,
    input  logic [DATA_W-1:0] reg1,
    input  logic [DATA_W-1:0] reg2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CMD_W-1:0]  ctrl_command,
    output logic [DATA_W-1:0] outreg1,
    output logic [DATA_W-1:0] outreg2,
    output logic              illegal,
    output logic              busy
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    // The first MULW cycle is the one after acceptance, so the counter
    // starts at MUL_LAT-2 and MULW lasts MUL_LAT-1 cycles.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);

    localparam logic [CMD_W-1:0] CMD_ADD = CMD_W'(0);
    localparam logic [CMD_W-1:0] CMD_SUB = CMD_W'(1);
    localparam logic [CMD_W-1:0] CMD_MUL = CMD_W'(2);
    localparam logic [CMD_W-1:0] CMD_AND = CMD_W'(3);
    localparam logic [CMD_W-1:0] CMD_OR  = CMD_W'(4);
    localparam logic [CMD_W-1:0] CMD_SLT = CMD_W'(5);
    localparam logic [CMD_W-1:0] CMD_XOR = CMD_W'(6);
    localparam logic [CMD_W-1:0] CMD_NOR = CMD_W'(7);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FULL,
        S_MULW
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] mul_cnt;
    logic [CMD_W-1:0] dec_cmd;
    logic             dec_illegal;
    logic             capture;

    always_comb begin
        dec_cmd     = CMD_ADD;
        dec_illegal = 1'b0;
        case (Op_from_control)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4: dec_cmd = CMD_W'(Op_from_control);
            4'd15: begin
                case (fonction)
                    6'h20, 6'h21: dec_cmd = CMD_ADD;
                    6'h22, 6'h23: dec_cmd = CMD_SUB;
                    6'h18, 6'h19: dec_cmd = CMD_MUL;
                    6'h24:        dec_cmd = CMD_AND;
                    6'h25:        dec_cmd = CMD_OR;
                    6'h26:        dec_cmd = CMD_XOR;
                    6'h27:        dec_cmd = CMD_NOR;
                    6'h2A:        dec_cmd = CMD_SLT;
                    default:      dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // A MUL being handed over cannot be replaced in the same cycle: the
    // outputs must stay on the MUL values while the ALU works on it.
    assign in_ready = rst_n &&
                      ((state == S_IDLE) ||
                       (state == S_FULL && out_ready && ctrl_command != CMD_MUL));
    assign capture  = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
            illegal      <= 1'b0;
            ctrl_command <= '0;
            outreg1      <= '0;
            outreg2      <= '0;
            mul_cnt      <= '0;
        end else begin
            if (capture) begin
                ctrl_command <= dec_cmd;
                outreg1      <= reg1;
                outreg2      <= reg2;
                illegal      <= dec_illegal;
            end
            case (state)
                S_IDLE: begin
                    if (capture) begin
                        state     <= S_FULL;
                        out_valid <= 1'b1;
                    end
                end
                S_FULL: begin
                    if (out_ready) begin
                        if (ctrl_command == CMD_MUL) begin
                            out_valid <= 1'b0;
                            if (MUL_LAT == 1) begin
                                state <= S_IDLE;
                            end else begin
                                state   <= S_MULW;
                                busy    <= 1'b1;
                                mul_cnt <= CNT_LOAD;
                            end
                        end else if (!capture) begin
                            state     <= S_IDLE;
                            out_valid <= 1'b0;
                        end
                    end
                end
                S_MULW: begin
                    if (mul_cnt == '0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        mul_cnt <= mul_cnt - 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: two instances (32-bit / MUL_LAT 4 and
// 16-bit / MUL_LAT 1) share stimulus; both are compared each cycle against
// a transaction-level model (occupancy flag + remaining stall cycles).
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  op;
    logic [5:0]  fn;
    logic [31:0] reg1, reg2;
    logic        out_ready;

    logic        in_ready, out_valid, illegal, busy;
    logic [3:0]  ctrl_command;
    logic [31:0] outreg1, outreg2;

    logic        in_ready_s, out_valid_s, illegal_s, busy_s;
    logic [3:0]  ctrl_command_s;
    logic [15:0] outreg1_s, outreg2_s;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DATA_W(32), .CMD_W(4), .MUL_LAT(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .Op_from_control(op), .fonction(fn),
        .reg1(reg1), .reg2(reg2),
        .out_valid(out_valid), .out_ready(out_ready),
        .ctrl_command(ctrl_command),
        .outreg1(outreg1), .outreg2(outreg2),
        .illegal(illegal), .busy(busy)
    );

    alu_issue_ctrl #(.DATA_W(16), .CMD_W(4), .MUL_LAT(1)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_s),
        .Op_from_control(op), .fonction(fn),
        .reg1(reg1[15:0]), .reg2(reg2[15:0]),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .ctrl_command(ctrl_command_s),
        .outreg1(outreg1_s), .outreg2(outreg2_s),
        .illegal(illegal_s), .busy(busy_s)
    );

    logic        g_ir[2], g_ov[2], g_ill[2], g_busy[2];
    logic [3:0]  g_cmd[2];
    logic [31:0] g_a[2], g_b[2];
    assign g_ir[0] = in_ready;     assign g_ir[1] = in_ready_s;
    assign g_ov[0] = out_valid;    assign g_ov[1] = out_valid_s;
    assign g_ill[0] = illegal;     assign g_ill[1] = illegal_s;
    assign g_busy[0] = busy;       assign g_busy[1] = busy_s;
    assign g_cmd[0] = ctrl_command; assign g_cmd[1] = ctrl_command_s;
    assign g_a[0] = outreg1;       assign g_a[1] = {16'h0, outreg1_s};
    assign g_b[0] = outreg2;       assign g_b[1] = {16'h0, outreg2_s};

    // Reference model state per instance
    bit          m_hold[2];
    int          m_stall[2];
    int          m_cmd[2];
    logic [31:0] m_a[2], m_b[2];
    bit          m_ill[2];
    int          lat[2];
    logic [31:0] wmask[2];
    logic [5:0]  legal_fn[11];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void ref_decode(input logic [3:0] o, input logic [5:0] f,
                                       output int cmd, output bit ill);
        cmd = 0;
        ill = 1'b0;
        if (o <= 4) cmd = int'(o);
        else if (o == 15) begin
            case (f)
                6'h20, 6'h21: cmd = 0;
                6'h22, 6'h23: cmd = 1;
                6'h18, 6'h19: cmd = 2;
                6'h24:        cmd = 3;
                6'h25:        cmd = 4;
                6'h2A:        cmd = 5;
                6'h26:        cmd = 6;
                6'h27:        cmd = 7;
                default:      ill = 1'b1;
            endcase
        end else ill = 1'b1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_hold[k] = 0; m_stall[k] = 0; m_cmd[k] = 0;
            m_a[k] = '0; m_b[k] = '0; m_ill[k] = 0;
        end
    endtask

    // Drive one cycle of inputs (called just after a falling edge), check
    // both instances against the model, advance the model, wait a cycle.
    task automatic step(input bit iv, input logic [3:0] o, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b, input bit ordy);
        int rc;
        bit ri;
        bit er;
        in_valid = iv; op = o; fn = f; reg1 = a; reg2 = b; out_ready = ordy;
        #1;
        ref_decode(o, f, rc, ri);
        for (int k = 0; k < 2; k++) begin
            er = (m_stall[k] == 0) && (!m_hold[k] || (ordy && m_cmd[k] != 2));
            chk($sformatf("in_ready[%0d]", k),  32'(g_ir[k]),   32'(er));
            chk($sformatf("out_valid[%0d]", k), 32'(g_ov[k]),   32'(m_hold[k]));
            chk($sformatf("busy[%0d]", k),      32'(g_busy[k]), 32'(m_stall[k] > 0));
            chk($sformatf("cmd[%0d]", k),       32'(g_cmd[k]),  32'(m_cmd[k]));
            chk($sformatf("outreg1[%0d]", k),   g_a[k],         m_a[k]);
            chk($sformatf("outreg2[%0d]", k),   g_b[k],         m_b[k]);
            chk($sformatf("illegal[%0d]", k),   32'(g_ill[k]),  32'(m_ill[k]));
            if (m_hold[k] && ordy) begin
                m_hold[k] = 0;
                if (m_cmd[k] == 2) m_stall[k] = lat[k] - 1;
            end else if (m_stall[k] > 0) begin
                m_stall[k]--;
            end
            if (iv && er) begin
                m_hold[k] = 1;
                m_cmd[k]  = rc;
                m_ill[k]  = ri;
                m_a[k]    = a & wmask[k];
                m_b[k]    = b & wmask[k];
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] ro;
        logic [5:0] rf;
        int r;

        lat[0] = 4; lat[1] = 1;
        wmask[0] = 32'hFFFF_FFFF; wmask[1] = 32'h0000_FFFF;
        legal_fn = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h18, 6'h19,
                     6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};

        rst_n = 1'b0; in_valid = 0; op = '0; fn = '0; reg1 = '0; reg2 = '0; out_ready = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cmd", 32'(ctrl_command), 0);
        chk("rst_outreg1", outreg1, 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 1);

        // SUB with operands 10 / 3
        step(1, 4'd1, 6'h0, 32'd10, 32'd3, 1);
        chk("sub_valid", 32'(out_valid), 1);
        chk("sub_cmd", 32'(ctrl_command), 1);
        chk("sub_a", outreg1, 10);
        chk("sub_b", outreg2, 3);
        chk("sub_illegal", 32'(illegal), 0);

        // Back-to-back R-type: SLT, NOR, undefined funct
        step(1, 4'd15, 6'h2A, 32'd1, 32'd2, 1);
        chk("b2b_slt", 32'(ctrl_command), 5);
        chk("b2b_slt_ill", 32'(illegal), 0);
        step(1, 4'd15, 6'h27, 32'd3, 32'd4, 1);
        chk("b2b_nor", 32'(ctrl_command), 7);
        chk("b2b_nor_ill", 32'(illegal), 0);
        step(1, 4'd15, 6'h3F, 32'd5, 32'd6, 1);
        chk("b2b_bad_cmd", 32'(ctrl_command), 0);
        chk("b2b_bad_ill", 32'(illegal), 1);
        chk("b2b_ready", 32'(in_ready), 1);
        step(0, 4'd0, 6'h0, 32'd0, 32'd0, 1);

        // MUL on the MUL_LAT=4 instance
        step(1, 4'd2, 6'h0, 32'd7, 32'd9, 1);
        step(0, 4'd0, 6'h0, 32'd0, 32'd0, 1);
        chk("mul16_no_busy", 32'(busy_s), 0);
        chk("mul16_ready", 32'(in_ready_s), 1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("mulw_busy%0d", i), 32'(busy), 1);
            chk($sformatf("mulw_ready%0d", i), 32'(in_ready), 0);
            chk($sformatf("mulw_cmd%0d", i), 32'(ctrl_command), 2);
            chk($sformatf("mulw_a%0d", i), outreg1, 7);
            step(1, 4'd0, 6'h0, $urandom, $urandom, 1);
        end
        chk("mul_done_busy", 32'(busy), 0);
        chk("mul_done_ready", 32'(in_ready), 1);

        // Backpressure with reg1 toggling
        step(1, 4'd0, 6'h0, 32'hAAAA, 32'h5, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 4'd3, 6'h0, (i % 2) ? 32'h1234 : 32'h5678, 32'h9, 0);
            chk($sformatf("bp_a%0d", i), outreg1, 32'hAAAA);
            chk($sformatf("bp_ready%0d", i), 32'(in_ready), 0);
            chk($sformatf("bp_valid%0d", i), 32'(out_valid), 1);
        end
        step(0, 4'd0, 6'h0, 32'd0, 32'd0, 1);
        chk("bp_drain_valid", 32'(out_valid), 0);
        chk("bp_drain_a", outreg1, 32'hAAAA);
        repeat (2) step(0, 4'd0, 6'h0, 32'd0, 32'd0, 1);

        // Asynchronous reset while in MULW
        step(1, 4'd2, 6'h0, 32'd3, 32'd4, 1);
        step(0, 4'd0, 6'h0, 32'd0, 32'd0, 1);
        chk("pre_rst_busy", 32'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_cmd", 32'(ctrl_command), 0);
        chk("arst_a", outreg1, 0);
        chk("arst_ready", 32'(in_ready), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst_rel_ready", 32'(in_ready), 1);

        // 16-bit MUL_LAT=1 instance: MUL returns straight to IDLE
        step(1, 4'd15, 6'h18, 32'h12345, 32'hABCDE, 1);
        chk("w16_a", {16'h0, outreg1_s}, 32'h2345);
        chk("w16_b", {16'h0, outreg2_s}, 32'hBCDE);
        chk("w16_cmd", 32'(ctrl_command_s), 2);
        step(0, 4'd0, 6'h0, 32'd0, 32'd0, 1);
        chk("w16_busy", 32'(busy_s), 0);
        chk("w16_valid", 32'(out_valid_s), 0);
        chk("w16_ready", 32'(in_ready_s), 1);
        step(1, 4'd15, 6'h19, 32'hF0F0F, 32'h1, 1);
        repeat (4) step(0, 4'd0, 6'h0, 32'd0, 32'd0, 1);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6) ro = (r == 5) ? 4'd15 : 4'(r);
            else       ro = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) < 7) rf = legal_fn[$urandom_range(0, 10)];
            else                          rf = 6'($urandom);
            step($urandom_range(0, 9) < 8, ro, rf, $urandom, $urandom,
                 $urandom_range(0, 9) < 7);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
